// File: rtl/div_iter_hs.sv
// Multi-cycle restoring integer divider (one quotient bit per cycle) with
// signed/unsigned mode, divide-by-zero flag, flush and valid/ready result handshake.
module div_iter_hs #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CALC  = 3'd1;
   localparam logic [2:0] S_FIX   = 3'd2;
   localparam logic [2:0] S_DZERO = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude, becomes quotient magnitude
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             valid_q, valid_d;
   logic             dz_q, dz_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   trial;
   logic             a_neg, b_neg;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         valid_q <= 1'b0;
         dz_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         valid_q <= valid_d;
         dz_q    <= dz_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      valid_d = valid_q;
      dz_d    = dz_q;
      a_neg   = signed_i & dividend_i[WIDTH-1];
      b_neg   = signed_i & divisor_i[WIDTH-1];
      shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
      trial   = {1'b0, shifted} - {1'b0, dsr_q};

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               neg_q_d = a_neg ^ b_neg;
               neg_r_d = a_neg;
               cnt_d   = '0;
               rem_d   = '0;
               dsr_d   = b_neg ? (-divisor_i) : divisor_i;
               // On divide-by-zero the original dividend is kept for the remainder
               if (divisor_i == '0) begin
                  dvd_d   = dividend_i;
                  state_d = S_DZERO;
               end else begin
                  dvd_d   = a_neg ? (-dividend_i) : dividend_i;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted;
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quot_d  = neg_q_q ? (-dvd_q) : dvd_q;
            remo_d  = neg_r_q ? (-rem_q) : rem_q;
            dz_d    = 1'b0;
            state_d = S_DONE;
         end
         S_DZERO: begin
            quot_d  = '1;
            remo_d  = dvd_q;
            dz_d    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // Valid rises one cycle after entering DONE
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (out_ready_i) begin
               valid_d = 1'b0;
               dz_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (flush_i) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         dz_d    = 1'b0;
      end

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   assign ready_o     = ready_q;
   assign busy_o      = busy_q;
   assign out_valid_o = valid_q;
   assign quotient_o  = quot_q;
   assign remainder_o = remo_q;
   assign div_zero_o  = dz_q;

endmodule

// File: doc/div_iter_hs.md
Name: div_iter_hs

Overview:
Parametrised multi-cycle restoring integer divider for the execute stage. It is the successor to the fixed 32-bit divider and adds:
- configurable operand width
- per-operation signed/unsigned mode
- a valid/ready result handshake with back-pressure
- an explicit divide-by-zero flag with defined results
- single-cycle flush

It produces one quotient bit per cycle and sits beside the ALU, stalling the pipeline via busy_o.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush_i  in  1  cancel any operation in flight (pipeline exception/annul)
start_i  in  1  request; accepted only when ready_o=1
signed_i  in  1  1=signed (two's complement), 0=unsigned; sampled at accept
dividend_i  in  WIDTH  dividend; sampled at accept
divisor_i  in  WIDTH  divisor; sampled at accept
ready_o  out  1  block idle, can accept start
busy_o  out  1  operation accepted and result not yet consumed (=~ready_o)
out_valid_o  out  1  result valid, held until out_ready_i
out_ready_i  in  1  consumer accepts result
quotient_o  out  WIDTH  quotient
remainder_o  out  WIDTH  remainder
div_zero_o  out  1  result came from divide-by-zero; valid with out_valid_o

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, ready_o=1, busy_o=0, out_valid_o=0, quotient_o=0, remainder_o=0, div_zero_o=0, counter=0.
  - Reset mid-operation abandons it; no result is produced.
- States: IDLE, CALC, FIX, DZERO, DONE.
- IDLE:
  - start_i=1 & flush_i=0 -> latch sign flags and magnitudes. Magnitude = two's-complement negate when signed_i & msb=1.
  - divisor_i==0 -> DZERO; else -> CALC with counter=0, partial remainder=0.
  - start_i is ignored in any other state; it is not queued.
- CALC (restoring, MSB first, one bit/cycle):
  - trial = {rem[WIDTH-2:0], next dividend bit} - divisor, computed WIDTH+1 bits wide.
  - trial non-negative -> rem=trial, quotient bit=1; else -> shift only, quotient bit=0.
  - counter increments each cycle; after WIDTH iterations -> FIX.
- FIX (1 cycle):
  - signed & (dividend sign ^ divisor sign) -> negate quotient.
  - signed & dividend negative -> negate remainder, so the remainder takes the dividend's sign.
  - Load outputs; -> DONE.
- DZERO (1 cycle): quotient={WIDTH{1}}, remainder=dividend_i as latched (original, not magnitude), div_zero_o=1; -> DONE.
- DONE:
  - out_valid_o=1; outputs stable while out_ready_i=0.
  - out_ready_i=1 -> IDLE next cycle; out_valid_o=0, div_zero_o=0, quotient_o/remainder_o keep their last value.
- Latency from the accept edge to out_valid_o=1:
  - normal: WIDTH+2 cycles
  - divide-by-zero: 2 cycles
- Signed overflow (MIN / -1): quotient=MIN (e.g. 0x80000000), remainder=0, div_zero_o=0; no trap.
- Dividend MIN, signed: magnitude 2^(WIDTH-1) is treated as unsigned; no special case.
- flush_i=1:
  - In any state, next state is IDLE; out_valid_o=0, div_zero_o=0; the operation is discarded.
  - flush_i has priority over start_i and out_ready_i in the same cycle.
  - rst has priority over flush_i.
- ready_o=1 only in IDLE; busy_o=~ready_o.
- out_valid_o and out_ready_i in DONE on the same edge as flush_i: the result is dropped and treated as not consumed.

Test Plan:
- Unsigned, WIDTH=32: 100/7 -> q=14, r=2, div_zero_o=0; out_valid_o rises exactly 34 cycles after the accept edge.
- Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1.
- Divide-by-zero: 5/0 (signed and unsigned) -> q=0xFFFFFFFF, r=5, div_zero_o=1, out_valid_o 2 cycles after accept. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- Back-pressure:
  - hold out_ready_i=0 for 10 cycles after valid -> outputs stable and ready_o=0 throughout.
  - raise out_ready_i -> ready_o=1 next cycle.
  - start_i pulsed in CALC is ignored: no second result.
- Flush/reset mid-CALC at iteration 10 -> IDLE next cycle, no out_valid_o. A following start 1000/10 returns q=100, r=0 with normal latency.
- WIDTH=8 build: signed -128/3 -> q=0xD6 (-42), r=0xFE (-2); latency 10 cycles.
